// File: rtl/clap_pkg.sv
// rtl/clap_pkg.sv - shared state encodings, default timing constants and helpers for the clap detector
package clap_pkg;

  // FSM state encodings (also driven out on clap_state_o for LEDs/debug)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FIRST   = 2'd1;
  localparam logic [1:0] ST_QUIET   = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  // Default timing constants, all counted in accepted samples
  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_LOUD_MAX = 8;
  localparam int DEF_GAP_MIN  = 4;
  localparam int DEF_GAP_MAX  = 20;
  localparam int DEF_HOLDOFF  = 16;

  // Largest of three integers, used to size the shared sample counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/clap_level_cmp.sv
// rtl/clap_level_cmp.sv - sample magnitude and registered threshold compare (CLAP_DETECTOR_ABS_EN selects signed input)
module clap_level_cmp
  import clap_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] threshold_i,
  output logic                loud_o,
  output logic                valid_o
);

  logic [SAMPLE_W-1:0] mag;
  logic                loud_d, loud_q;
  logic                valid_d, valid_q;

`ifdef CLAP_DETECTOR_ABS_EN
  localparam logic [SAMPLE_W-1:0] SMP_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] SMP_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  // Signed magnitude; the most negative code saturates to the largest positive one
  always_comb begin
    mag = sample_i;
    if (sample_i[SAMPLE_W-1]) begin
      if (sample_i == SMP_MIN) begin
        mag = SMP_MAX;
      end else begin
        mag = -sample_i;
      end
    end
  end
`else
  // Unsigned samples are their own magnitude
  always_comb begin
    mag = sample_i;
  end
`endif

  // Threshold compare; a zero threshold makes every sample loud
  always_comb begin
    loud_d  = (mag >= threshold_i);
    valid_d = sample_valid_i;
  end

  // Stage-1 pipeline register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      loud_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      loud_q  <= loud_d;
      valid_q <= valid_d;
    end
  end

  assign loud_o  = loud_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/clap_detector.sv
// rtl/clap_detector.sv - double-clap detector: level compare, gap-timing FSM, one-cycle clap_set_o pulse (option CLAP_DETECTOR_ABS_EN)
module clap_detector
  import clap_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int LOUD_MAX = DEF_LOUD_MAX,
  parameter int GAP_MIN  = DEF_GAP_MIN,
  parameter int GAP_MAX  = DEF_GAP_MAX,
  parameter int HOLDOFF  = DEF_HOLDOFF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] threshold_i,
  output logic                clap_set_o,
  output logic [1:0]          clap_state_o
);

  localparam int CW = $clog2(max3(LOUD_MAX, GAP_MAX, HOLDOFF) + 2);

  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_SAT   = '1;
  localparam logic [CW-1:0] LOUD_LIM  = CW'(LOUD_MAX + 1);
  localparam logic [CW-1:0] GAP_LO    = CW'(GAP_MIN);
  localparam logic [CW-1:0] GAP_LIM   = CW'(GAP_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLDOFF);

  logic          loud, v1;
  logic [1:0]    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          det_d, det_q;
  logic          clap_d, clap_q;

  clap_level_cmp #(
    .SAMPLE_W(SAMPLE_W)
  ) u_level_cmp (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .threshold_i   (threshold_i),
    .loud_o        (loud),
    .valid_o       (v1)
  );

  // Saturating increment of the shared sample counter
  always_comb begin
    cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_ONE);
  end

  // State, counter, detection flag and output pulse registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      det_q   <= 1'b0;
      clap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      clap_q  <= clap_d;
    end
  end

  // Next state and counter; nothing moves unless a stage-1 sample is valid
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (v1) begin
      unique case (state_q)
        ST_IDLE: begin
          if (loud) begin
            state_d = ST_FIRST;
            cnt_d   = CNT_ONE;
          end
        end
        ST_FIRST: begin
          if (loud) begin
            if (cnt_inc == LOUD_LIM) begin
              // Too long to be a clap: treat as continuous noise
              state_d = ST_HOLDOFF;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_QUIET;
            cnt_d   = CNT_ONE;
          end
        end
        ST_QUIET: begin
          if (loud) begin
            if (cnt_q >= GAP_LO) begin
              state_d = ST_HOLDOFF;
              cnt_d   = CNT_ZERO;
            end else begin
              // Gap too short: an echo, so this loud sample restarts clap one
              state_d = ST_FIRST;
              cnt_d   = CNT_ONE;
            end
          end else if (cnt_inc == GAP_LIM) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HOLDOFF: begin
          if ((cnt_inc >= HOLD_LIM) && !loud) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Outputs: detection is flagged on the QUIET->HOLDOFF edge, then re-registered for the pulse
  always_comb begin
    det_d        = v1 && loud && (state_q == ST_QUIET) && (cnt_q >= GAP_LO);
    clap_d       = det_q;
    clap_set_o   = clap_q;
    clap_state_o = state_q;
  end

endmodule

// File: tb/tb_clap_detector.sv
// tb/tb_clap_detector.sv - directed self-checking bench for clap_detector
module tb_clap_detector;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] sample_i = 8'd0;
  logic       sample_valid_i = 1'b0;
  logic [7:0] threshold_i = 8'd100;
  logic       clap_set_o;
  logic [1:0] clap_state_o;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int pulse_total = 0;
  int last_pulse_edge = 0;
  int acc_edge;
  int base;

  localparam logic [7:0] LOUD  = 8'd120;
  localparam logic [7:0] QUIET = 8'd10;

  clap_detector dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .threshold_i   (threshold_i),
    .clap_set_o    (clap_set_o),
    .clap_state_o  (clap_state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  always @(negedge clk_i) begin
    if (clap_set_o) begin
      pulse_total     = pulse_total + 1;
      last_pulse_edge = edge_cnt;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] s, input logic v);
    @(negedge clk_i);
    sample_i       = s;
    sample_valid_i = v;
    @(posedge clk_i);
    #1;
    acc_edge = edge_cnt;
  endtask

  task automatic send(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni         = 1'b0;
    sample_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    base   = pulse_total;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("reset_state", clap_state_o, 0);
    check("reset_pulse", clap_set_o, 0);

    // 1: clean double clap, pulse two edges after the 9th sample
    send(LOUD, 2);
    send(QUIET, 6);
    send(LOUD, 1);
    begin
      int a9;
      a9 = acc_edge;
      send(LOUD, 1);
      idle(3);
      check("t1_pulses", pulse_total - base, 1);
      check("t1_latency", last_pulse_edge - a9, 2);
    end
    check("t1_holdoff", clap_state_o, 3);
    send(QUIET, 20);
    idle(2);
    check("t1_holdoff_exit", clap_state_o, 0);

    // 2: echo restart then GAP_MAX timeout
    do_reset();
    send(LOUD, 2);
    send(QUIET, 2);
    send(LOUD, 1);
    idle(2);
    check("t2_echo_first", clap_state_o, 1);
    send(LOUD, 1);
    send(QUIET, 25);
    idle(3);
    check("t2_pulses", pulse_total - base, 0);
    check("t2_idle", clap_state_o, 0);

    // 3: continuous noise goes to HOLDOFF on the 9th loud sample
    do_reset();
    send(LOUD, 8);
    idle(2);
    check("t3_first_at8", clap_state_o, 1);
    send(LOUD, 1);
    idle(2);
    check("t3_holdoff_at9", clap_state_o, 3);
    send(LOUD, 3);
    send(QUIET, 1);
    send(LOUD, 1);
    idle(3);
    check("t3_pulses", pulse_total - base, 0);
    check("t3_still_holdoff", clap_state_o, 3);

    // GAP_MIN boundary: 3 quiet is an echo, 4 quiet is a clap
    do_reset();
    send(LOUD, 2);
    send(QUIET, 3);
    send(LOUD, 1);
    idle(3);
    check("gmin3_state", clap_state_o, 1);
    check("gmin3_pulses", pulse_total - base, 0);
    send(QUIET, 4);
    send(LOUD, 1);
    idle(3);
    check("gmin4_pulses", pulse_total - base, 1);

    // GAP_MAX boundary: 20 quiet still a clap, 21 quiet times out
    do_reset();
    send(LOUD, 1);
    send(QUIET, 20);
    send(LOUD, 1);
    idle(3);
    check("gmax20_pulses", pulse_total - base, 1);
    do_reset();
    send(LOUD, 1);
    send(QUIET, 21);
    idle(2);
    check("gmax21_idle", clap_state_o, 0);
    send(LOUD, 1);
    idle(3);
    check("gmax21_first", clap_state_o, 1);
    check("gmax21_pulses", pulse_total - base, 0);

    // 4: valid held low mid-gap freezes the FSM
    do_reset();
    send(LOUD, 2);
    send(QUIET, 3);
    idle(50);
    check("t4_frozen", clap_state_o, 2);
    send(QUIET, 3);
    send(LOUD, 1);
    begin
      int a;
      a = acc_edge;
      idle(3);
      check("t4_pulses", pulse_total - base, 1);
      check("t4_latency", last_pulse_edge - a, 2);
    end

    // 5: reset in QUIET aborts the detection
    do_reset();
    send(LOUD, 2);
    send(QUIET, 5);
    idle(2);
    check("t5_quiet", clap_state_o, 2);
    do_reset();
    check("t5_rst_state", clap_state_o, 0);
    check("t5_rst_pulse", clap_set_o, 0);
    send(LOUD, 1);
    idle(3);
    check("t5_second_first", clap_state_o, 1);
    check("t5_pulses", pulse_total - base, 0);

    // 6: 0x88 / 0x80 are loud both as signed magnitude and as unsigned
    do_reset();
    send(8'h88, 1);
    send(QUIET, 5);
    send(8'h80, 1);
    idle(3);
    check("t6_pulses", pulse_total - base, 1);

    // Threshold edges: equal is loud, one below is quiet, zero is always loud
    do_reset();
    send(8'd99, 1);
    idle(2);
    check("thr_below", clap_state_o, 0);
    send(8'd100, 1);
    idle(2);
    check("thr_equal", clap_state_o, 1);
    do_reset();
    threshold_i = 8'd0;
    send(8'd0, 1);
    idle(2);
    check("thr_zero", clap_state_o, 1);
    threshold_i = 8'd100;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
